// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and default sizing for the RAM arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;
  localparam int AW_DEF       = 7;
  localparam int DW_DEF       = 16;
  localparam int MAX_HOLD_DEF = 4;
endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin chooser, the port that did not go last wins a tie
module rr_pick2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_win,
  output logic o_vld
);
  assign o_vld = i_req0 | i_req1;
  assign o_win = (i_req0 & i_req1) ? !i_last : i_req1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between the processor (port 0) and a DMA/loader (port 1)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic          r0_lock,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_ack,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic          r1_lock,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_ack,
  output logic [DW-1:0] r1_rdata,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);
  state_t r_state, w_state_nxt;
  logic [HW-1:0] r_hold, w_hold_nxt;
  logic r_last, w_last_nxt;
  logic r_ack0, r_ack1;
  logic [DW-1:0] r_rdata0, r_rdata1;
  logic w_owned, w_own, w_req_x, w_req_y, w_we_x, w_lock_x, w_xfer, w_stay;
  logic w_pick, w_pick_vld;
  logic [AW-1:0] w_addr_x;
  logic [DW-1:0] w_wdata_x;
  assign w_owned   = r_state != IDLE;
  assign w_own     = r_state == OWN1;
  assign w_req_x   = w_own ? r1_req   : r0_req;
  assign w_req_y   = w_own ? r0_req   : r1_req;
  assign w_we_x    = w_own ? r1_we    : r0_we;
  assign w_lock_x  = w_own ? r1_lock  : r0_lock;
  assign w_addr_x  = w_own ? r1_addr  : r0_addr;
  assign w_wdata_x = w_own ? r1_wdata : r0_wdata;
  assign w_xfer    = w_owned & w_req_x;
  assign w_stay    = w_xfer & w_lock_x & (!w_req_y | (r_hold < HOLD_MAX));
  // The tie-break must already see this cycle's transfer, or two unlocked requesters would not alternate
  assign w_last_nxt = w_xfer ? w_own : r_last;
  rr_pick2 u_pick (
    .i_req0 (r0_req),
    .i_req1 (r1_req),
    .i_last (w_last_nxt),
    .o_win  (w_pick),
    .o_vld  (w_pick_vld)
  );
  always_comb begin
    w_state_nxt = w_stay ? r_state : !w_pick_vld ? IDLE : w_pick ? OWN1 : OWN0;
    w_hold_nxt  = w_stay ? ((r_hold == HOLD_MAX) ? r_hold : r_hold + 1'b1)
                         : ((w_state_nxt != r_state) ? '0 : r_hold);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_last  <= w_last_nxt;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_ack0 <= w_xfer & !w_own;
      r_ack1 <= w_xfer & w_own;
      if (w_xfer & !w_own & !w_we_x) r_rdata0 <= mem_rdata;
      if (w_xfer & w_own & !w_we_x) r_rdata1 <= mem_rdata;
    end
  end
  assign mem_wr    = w_xfer & w_we_x;
  assign mem_addr  = w_owned ? w_addr_x : '0;
  assign mem_wdata = w_owned ? w_wdata_x : '0;
  assign r0_gnt    = r_state == OWN0;
  assign r1_gnt    = w_own;
  assign r0_ack    = r_ack0;
  assign r1_ack    = r_ack1;
  assign r0_rdata  = r_rdata0;
  assign r1_rdata  = r_rdata1;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural 128x16 RAM
module tb_mem_arbiter;
  localparam int AW = 7;
  localparam int DW = 16;
  typedef struct packed {
    logic          port;
    logic [DW-1:0] rdata;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  logic r0_req, r0_we, r0_lock, r0_gnt, r0_ack;
  logic r1_req, r1_we, r1_lock, r1_gnt, r1_ack;
  logic [AW-1:0] r0_addr, r1_addr, mem_addr;
  logic [DW-1:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata, mem_wdata, mem_rdata;
  logic mem_wr;
  logic [DW-1:0] ram [128];
  logic [DW-1:0] gold [128];
  logic [DW-1:0] exp_rd [2];
  logic ram_ok = 1'b0;
  exp_t q[$];
  exp_t mon_e;
  int n_chk = 0;
  int n_fail = 0;
  int n_wr = 0;
  int wr0;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int i);
    return (i == 10) ? 16'h00D8 : DW'((i * 257) ^ 16'h3c5a);
  endfunction

  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) begin
    if (!ram_ok) begin
      for (int i = 0; i < 128; i++) ram[i] <= init_val(i);
      ram_ok <= 1'b1;
    end else if (mem_wr) ram[mem_addr] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_wr) n_wr++;
    if (r0_ack | r1_ack) begin
      if (q.size() == 0) check("ack_unexpected", {r1_ack, r0_ack}, 0);
      else begin
        mon_e = q.pop_front();
        check("ack_port", {r1_ack, r0_ack}, mon_e.port ? 32'd2 : 32'd1);
        check("ack_rdata", mon_e.port ? r1_rdata : r0_rdata, mon_e.rdata);
      end
    end
  end

  task automatic expect_xfer(input int port, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata);
    exp_t e;
    if (we) gold[addr] = wdata;
    else exp_rd[port] = gold[addr];
    e.port  = port[0];
    e.rdata = exp_rd[port];
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    r0_req = 0; r0_we = 0; r0_lock = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_we = 0; r1_lock = 0; r1_addr = '0; r1_wdata = '0;
  endtask

  task automatic do_reset();
    clr();
    reset = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 128; i++) gold[i] = init_val(i);
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    clr();
    reset = 1;
    #1 reset = 0;
    #1;
    check("rst_gnt", {r1_gnt, r0_gnt}, 0);
    check("rst_ack", {r1_ack, r0_ack}, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rdata0", r0_rdata, 0);
    check("rst_rdata1", r1_rdata, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;

    r0_req = 1; r0_addr = 10;
    expect_xfer(0, 0, 10, 0);
    tick();
    check("t1_gnt", {r1_gnt, r0_gnt}, 1);
    #1;
    check("t1_addr", mem_addr, 10);
    check("t1_wr", mem_wr, 0);
    tick();
    check("t1_ack0", r0_ack, 1);
    check("t1_rdata0", r0_rdata, 16'h00D8);
    check("t1_ack1", r1_ack, 0);
    r0_req = 0;
    tick();
    check("t1_gnt_off", r0_gnt, 0);
    check("t1_ack_pulse", r0_ack, 0);

    wr0 = n_wr;
    r1_req = 1; r1_we = 1; r1_addr = 127; r1_wdata = 16'hBEEF;
    expect_xfer(1, 1, 127, 16'hBEEF);
    tick();
    check("t2_gnt", {r1_gnt, r0_gnt}, 2);
    #1;
    check("t2_wr", mem_wr, 1);
    check("t2_wdata", mem_wdata, 16'hBEEF);
    tick();
    check("t2_wr_ack", r1_ack, 1);
    r1_we = 0;
    expect_xfer(1, 0, 127, 0);
    tick();
    check("t2_rd_ack", r1_ack, 1);
    check("t2_rdata", r1_rdata, 16'hBEEF);
    r1_req = 0;
    tick();
    check("t2_wr_pulses", n_wr - wr0, 1);
    check("t2_ram", ram[127], 16'hBEEF);

    r0_req = 1; r0_we = 1; r0_addr = 5; r0_wdata = 16'h1111;
    tick();
    check("t5_gnt", r0_gnt, 1);
    r0_req = 0;
    #1;
    check("t5_wr", mem_wr, 0);
    tick();
    check("t5_ack", r0_ack, 0);
    check("t5_idle", {r1_gnt, r0_gnt}, 0);
    check("t5_ram", ram[5], gold[5]);

    do_reset();
    r0_req = 1; r0_addr = 1; r1_req = 1; r1_addr = 2;
    tick();
    for (int i = 0; i < 6; i++) begin
      check("t3_gnt", {r1_gnt, r0_gnt}, (i % 2) ? 2 : 1);
      expect_xfer(i % 2, 0, (i % 2) ? 7'd2 : 7'd1, 0);
      tick();
    end
    clr();
    tick();
    tick();
    check("t3_drain", q.size(), 0);

    do_reset();
    r0_req = 1; r0_lock = 1; r0_addr = 3; r1_addr = 4;
    tick();
    for (int i = 0; i < 11; i++) begin
      r1_req = (i >= 1 && i <= 4);
      check("t4_gnt", {r1_gnt, r0_gnt}, (i == 4) ? 2 : 1);
      expect_xfer((i == 4) ? 1 : 0, 0, (i == 4) ? 7'd4 : 7'd3, 0);
      tick();
    end
    clr();
    tick();
    tick();
    check("t4_drain", q.size(), 0);

    r1_req = 1; r1_we = 1; r1_addr = 50; r1_wdata = 16'h1234;
    tick();
    check("t6_gnt", r1_gnt, 1);
    #1;
    check("t6_wr", mem_wr, 1);
    #1 reset = 0;
    #1;
    check("t6_wr_drop", mem_wr, 0);
    check("t6_gnt_drop", {r1_gnt, r0_gnt}, 0);
    check("t6_ack_drop", {r1_ack, r0_ack}, 0);
    clr();
    @(posedge clk);
    #1;
    check("t6_ram", ram[50], gold[50]);
    reset = 1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    r0_req = 1; r0_addr = 20; r1_req = 1; r1_addr = 21;
    tick();
    check("t6_first_tie", {r1_gnt, r0_gnt}, 1);
    expect_xfer(0, 0, 20, 0);
    tick();
    check("t6_second", {r1_gnt, r0_gnt}, 2);
    clr();
    tick();
    tick();
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
